// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key encoder: key indices, scancodes, prefixes, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ps2_pkg;

    localparam int NUM_KEYS   = 5;
    localparam int FRAME_BITS = 11;

    // Key indices into the keys vector
    localparam logic [2:0] KEY_LEFT  = 3'd0;
    localparam logic [2:0] KEY_RIGHT = 3'd1;
    localparam logic [2:0] KEY_UP    = 3'd2;
    localparam logic [2:0] KEY_DOWN  = 3'd3;
    localparam logic [2:0] KEY_KILL  = 3'd4;

    // Set-2 scancodes; all but kill are extended (E0-prefixed)
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_KILL  = 8'h29;
    localparam logic [7:0] PFX_EXT  = 8'hE0;
    localparam logic [7:0] PFX_BRK  = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } state_t;

    function automatic logic [7:0] key_code(input logic [2:0] key);
        case (key)
            KEY_LEFT:  key_code = SC_LEFT;
            KEY_RIGHT: key_code = SC_RIGHT;
            KEY_UP:    key_code = SC_UP;
            KEY_DOWN:  key_code = SC_DOWN;
            default:   key_code = SC_KILL;
        endcase
    endfunction

    // Index of the final byte of a sequence: extended adds one, break adds one
    function automatic logic [1:0] seq_last(input logic [2:0] key, input logic lvl);
        logic ext;
        ext      = (key != KEY_KILL);
        seq_last = {1'b0, ext} + {1'b0, ~lvl};
    endfunction

    // Byte at position idx of the make (lvl=1) or break (lvl=0) sequence
    function automatic logic [7:0] seq_byte(input logic [2:0] key, input logic lvl,
                                            input logic [1:0] idx);
        logic       ext;
        logic [7:0] code;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        ext  = (key != KEY_KILL);
        code = key_code(key);
        b0   = code;
        b1   = code;
        b2   = code;
        if (ext && !lvl) begin
            b0 = PFX_EXT;
            b1 = PFX_BRK;
        end else if (ext) begin
            b0 = PFX_EXT;
        end else if (!lvl) begin
            b0 = PFX_BRK;
        end
        case (idx)
            2'd0:    seq_byte = b0;
            2'd1:    seq_byte = b1;
            default: seq_byte = b2;
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Serializes one byte as an 11-bit PS/2 device frame (start, 8 data LSB first, odd parity, stop).
// Latency: start bit on the lines the cycle after i_start; o_done pulses the cycle after the stop bit ends.
// Backpressure: i_start is only accepted while o_rdy is high; lines idle high otherwise.
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 2500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_rdy,
    output logic       o_done,
    output logic       o_ps2_clk,
    output logic       o_ps2_data
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = $clog2(FRAME_BITS);

    logic             r_active;
    logic             r_done;
    logic             r_clk;
    logic             r_data;
    logic [DIV_W-1:0] r_div;
    logic [BIT_W-1:0] r_bit;
    // Bits still to send after the start bit: {stop, parity, data[7:0]}
    logic [9:0]       r_shift;

    // Bit timing: data changes at bit start, clock high for the first half, low for the second
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_clk    <= 1'b1;
            r_data   <= 1'b1;
            r_div    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_active) begin
                if (i_start) begin
                    r_active <= 1'b1;
                    r_shift  <= {1'b1, ~^i_byte, i_byte};
                    r_data   <= 1'b0;
                    r_clk    <= 1'b1;
                    r_div    <= '0;
                    r_bit    <= '0;
                end
            end else if (r_div == DIV_W'(2 * CLK_DIV - 1)) begin
                r_div <= '0;
                r_clk <= 1'b1;
                if (r_bit == BIT_W'(FRAME_BITS - 1)) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                    r_data   <= 1'b1;
                end else begin
                    r_bit   <= r_bit + 1'b1;
                    r_data  <= r_shift[0];
                    r_shift <= {1'b1, r_shift[9:1]};
                end
            end else begin
                r_div <= r_div + 1'b1;
                if (r_div == DIV_W'(CLK_DIV - 1)) begin
                    r_clk <= 1'b0;
                end
            end
        end
    end

    assign o_rdy      = ~r_active;
    assign o_done     = r_done;
    assign o_ps2_clk  = r_clk;
    assign o_ps2_data = r_data;

endmodule

// File: rtl/ps2_key_encoder.sv
// Turns 5 level key inputs into PS/2 make/break scancode sequences; PS2_TYPEMATIC_EN adds auto-repeat.
// Latency: keys change at cycle N gives busy=1 and the start bit at cycle N+2.
// Backpressure: none; changes accumulate as keys-vs-reported differences and are served one sequence at a time.
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int CLK_DIV          = 2500,
    parameter int GAP_BITS         = 2,
    parameter int TYPEMATIC_DELAY  = 25000000,
    parameter int TYPEMATIC_PERIOD = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] keys,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    // The done-pulse cycle and the LOAD cycle are also idle-high, so GAP covers the rest
    localparam int GAP_CYC = GAP_BITS * 2 * CLK_DIV - 2;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t               r_state;
    logic [NUM_KEYS-1:0]  r_reported;
    logic [2:0]           r_key;
    logic                 r_lvl;
    logic [1:0]           r_idx;
    logic [GAP_W-1:0]     r_gap;
    logic                 r_busy;

    logic [NUM_KEYS-1:0]  w_diff;
    logic [2:0]           w_sel;
    logic                 w_pending;
    logic                 w_last;
    logic [7:0]           w_byte;
    logic                 w_tx_start;
    logic                 w_tx_rdy;
    logic                 w_tx_done;

`ifdef PS2_TYPEMATIC_EN
    localparam int TM_MAX = (TYPEMATIC_DELAY > TYPEMATIC_PERIOD) ? TYPEMATIC_DELAY : TYPEMATIC_PERIOD;
    localparam int TM_W   = (TM_MAX > 1) ? $clog2(TM_MAX) : 1;

    logic             r_rpt_vld;
    logic             r_rpt_first;
    logic             r_is_rpt;
    logic [TM_W-1:0]  r_rpt_cnt;
    logic [TM_W-1:0]  w_rpt_end;

    assign w_rpt_end = r_rpt_first ? TM_W'(TYPEMATIC_DELAY - 1) : TM_W'(TYPEMATIC_PERIOD - 1);
`else
    // Repeat timing parameters have no effect in this build
    logic w_unused_tm;
    assign w_unused_tm = ^{TYPEMATIC_DELAY, TYPEMATIC_PERIOD};
`endif

    assign w_diff    = keys ^ r_reported;
    assign w_pending = |w_diff;
    assign w_last    = (r_idx == seq_last(r_key, r_lvl));
    assign w_byte    = seq_byte(r_key, r_lvl, r_idx);
    assign w_tx_start = (r_state == ST_LOAD) && w_tx_rdy;

    // Lowest-index differing key wins
    always_comb begin
        w_sel = 3'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_sel = 3'(i);
            end
        end
    end

    // Sequence FSM: pick a key, walk its bytes with a gap after each, commit reported state at the end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_reported <= '0;
            r_key      <= '0;
            r_lvl      <= 1'b0;
            r_idx      <= '0;
            r_gap      <= '0;
            r_busy     <= 1'b0;
`ifdef PS2_TYPEMATIC_EN
            r_rpt_vld   <= 1'b0;
            r_rpt_first <= 1'b0;
            r_is_rpt    <= 1'b0;
            r_rpt_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pending) begin
                        r_key   <= w_sel;
                        r_lvl   <= keys[w_sel];
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
`ifdef PS2_TYPEMATIC_EN
                        r_rpt_vld <= 1'b0;
                        r_is_rpt  <= 1'b0;
`endif
                    end
`ifdef PS2_TYPEMATIC_EN
                    else if (r_rpt_vld) begin
                        if (r_rpt_cnt == w_rpt_end) begin
                            // r_key still names the last pressed key
                            r_rpt_vld <= 1'b0;
                            r_is_rpt  <= 1'b1;
                            r_lvl     <= 1'b1;
                            r_idx     <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= ST_LOAD;
                        end else begin
                            r_rpt_cnt <= r_rpt_cnt + 1'b1;
                        end
                    end
`endif
                end
                ST_LOAD: begin
                    if (w_tx_rdy) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_tx_done) begin
                        r_gap   <= '0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_W'(GAP_CYC - 1)) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_LOAD;
                        end
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_reported[r_key] <= r_lvl;
                    r_busy            <= 1'b0;
                    r_state           <= ST_IDLE;
`ifdef PS2_TYPEMATIC_EN
                    if (r_lvl) begin
                        r_rpt_vld   <= 1'b1;
                        r_rpt_first <= ~r_is_rpt;
                        r_rpt_cnt   <= '0;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    ps2_frame_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_frame_tx (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_tx_start),
        .i_byte     (w_byte),
        .o_rdy      (w_tx_rdy),
        .o_done     (w_tx_done),
        .o_ps2_clk  (ps2_clk),
        .o_ps2_data (ps2_data)
    );

    assign busy = r_busy;

endmodule

// File: doc/ps2_key_encoder.md
PS2_KEY_ENCODER -- requirements
Module: ps2_key_encoder

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2500, giving the PS/2 clock half-period in clk cycles.
REQ-002 The block SHALL have parameter GAP_BITS, default 2, giving the idle gap between bytes in bit periods.
REQ-003 The block SHALL have parameters TYPEMATIC_DELAY, default 25000000, and TYPEMATIC_PERIOD, default 5000000, both in clk cycles and used only under PS2_TYPEMATIC_EN.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port keys, input, 5 bits: level key state, synchronous to clk; [0]=left, [1]=right, [2]=up, [3]=down, [4]=kill.
REQ-007 The block SHALL have port ps2_clk, output, 1 bit: device-side PS/2 clock, idle high.
REQ-008 The block SHALL have port ps2_data, output, 1 bit: device-side PS/2 data, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a byte sequence is in progress, including inter-byte gaps.

Function
REQ-010 Scancodes SHALL be: left E0 6B, right E0 74, up E0 75, down E0 72, kill 29 (non-extended).
REQ-011 A press (0 to 1) SHALL emit the make sequence: [E0,] code.
REQ-012 A release (1 to 0) SHALL emit the break sequence: [E0,] F0, code.
REQ-013 The block SHALL hold a 5-bit reported-state register and an event SHALL exist whenever keys differs from reported.
REQ-014 In IDLE with an event pending, the lowest-index differing key SHALL be served, and its new level SHALL be snapshotted at that cycle.
REQ-015 The reported bit for a key SHALL update only when the last byte of its sequence completes.
REQ-016 A key changing again mid-sequence SHALL NOT abort the sequence; any remaining difference SHALL be served afterwards.
REQ-017 Simultaneous changes SHALL be served one sequence at a time in index order, with no sequence lost.
REQ-018 The FSM SHALL have states IDLE, LOAD (select next byte), SHIFT (frame serialize), GAP and DONE (update reported, return to IDLE).
REQ-019 Each frame SHALL be 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-020 Each bit SHALL be 2*CLK_DIV cycles: ps2_data changes at bit start with ps2_clk high for CLK_DIV cycles, then ps2_clk low for CLK_DIV cycles.
REQ-021 After each byte, ps2_clk and ps2_data SHALL both stay high for GAP_BITS*2*CLK_DIV cycles, including after the last byte, before busy falls.
REQ-022 Latency SHALL be: keys differs at cycle N, busy=1 and ps2_data=0 (start bit) at cycle N+2.
REQ-023 Divider and bit counters SHALL be sized by $clog2 of their maxima, and parity SHALL be computed as the complement of the XOR-reduce of the byte.

Reset
REQ-024 While rst=0, ps2_clk=1, ps2_data=1, busy=0, reported=0, the FSM SHALL be in IDLE, and all counters SHALL be cleared.
REQ-025 Reset asserted mid-frame SHALL abandon the sequence immediately with no partial completion.
REQ-026 After reset release, keys already held SHALL be reported as presses.

Configuration
REQ-027 With macro PS2_TYPEMATIC_EN defined, the most recently pressed key, if still held and no other event is pending, SHALL re-emit its make sequence TYPEMATIC_DELAY cycles after its make completes and then every TYPEMATIC_PERIOD cycles.
REQ-028 Under PS2_TYPEMATIC_EN, any other event SHALL cancel repeat, and a release of the repeating key SHALL stop repeat.
REQ-029 Without PS2_TYPEMATIC_EN, only state changes SHALL emit codes and no typematic counters SHALL exist.

Structure
REQ-030 Package ps2_pkg SHALL hold the scancode constants, the E0 and F0 prefixes, the key index constants and the FSM state enum.
REQ-031 One sub-module SHALL exist: ps2_frame_tx, which serializes one byte with start, stop and handshake signals and owns the divider and bit counter.

Verification
REQ-032 With CLK_DIV=4 and GAP_BITS=2, keys 00000 to 00001 -> frames E0 then 6B, each 88 cycles with a 16-cycle gap, then reported[0]=1.
REQ-033 Then keys 00001 to 00000 -> frames E0, F0, 6B; parity bits 0, 1, 0.
REQ-034 Keys 00000 to 10100 in one cycle -> make for up (E0 75), then make for kill (29).
REQ-035 Press left, then release it during the E0 frame -> full make E0 6B, then break E0 F0 6B, then idle.
REQ-036 Assert rst during bit 5 of a frame -> the next cycle shows ps2_clk=1, ps2_data=1, busy=0; after release with left held -> make re-emitted.
REQ-037 Under PS2_TYPEMATIC_EN with TYPEMATIC_DELAY=1000 and TYPEMATIC_PERIOD=500, hold down -> E0 72 at press, repeated 1000 cycles and then every 500 cycles after each completion; repeat stops on release.
